// File: rtl/lut_mult_pkg.sv
// lut_mult_pkg: shared constants and FSM state type for the LUT multiplier
// sequencer (lut_mult_seq) and its byte slice (lut_byte_mult).
package lut_mult_pkg;

   // Operands are consumed one byte per cycle.
   localparam int CHUNK_W   = 8;
   // Each byte is split into two nibbles; each nibble addresses an 8-word table.
   localparam int NIB_W     = 4;
   localparam int LUT_IDX_W = 3;
   localparam int LUT_DEPTH = 1 << LUT_IDX_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter width for n items, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lut_byte_mult.sv
// lut_byte_mult: combinational 8-bit unsigned x constant multiplier.
// Each nibble is multiplied through an 8-word table holding k*A_CONST for
// k=0..7. Nibbles 8..15 fold onto the same table: with j = ~nib[2:0] = 15-nib,
// nib*A = 15A - j*A, done as 15A + ~table[j] + 1 (sign modification plus
// increment). The two nibble products are recombined as hi<<4 + lo.
module lut_byte_mult
   import lut_mult_pkg::*;
#(
   parameter int unsigned A_CONST = 2,
   parameter int          A_W     = 8
) (
   input  logic [CHUNK_W-1:0]     x_i,
   output logic [CHUNK_W+A_W-1:0] p_o
);

   localparam int LW  = LUT_IDX_W + A_W;   // holds 7*A
   localparam int NW  = NIB_W + A_W;       // holds 15*A
   localparam int PPW = CHUNK_W + A_W;
   localparam logic [NW-1:0] A15 = NW'(15 * A_CONST);

   logic [LW-1:0] lut [LUT_DEPTH];
   logic [NW-1:0] nib_pp [2];

   // Constant table: entry k is k*A_CONST.
   for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
      assign lut[k] = LW'(k * A_CONST);
   end

   // One table lookup per nibble, with the upper half of the range mirrored.
   for (genvar n = 0; n < 2; n++) begin : g_nib
      logic [NIB_W-1:0]     nib;
      logic [LUT_IDX_W-1:0] sel;
      logic [NW-1:0]        word;
      assign nib       = x_i[n*NIB_W +: NIB_W];
      assign sel       = nib[NIB_W-1] ? ~nib[LUT_IDX_W-1:0] : nib[LUT_IDX_W-1:0];
      assign word      = NW'(lut[sel]);
      assign nib_pp[n] = nib[NIB_W-1] ? (A15 + ~word + NW'(1)) : word;
   end

   assign p_o = {nib_pp[1], {NIB_W{1'b0}}} + PPW'(nib_pp[0]);

endmodule

// File: rtl/lut_mult_seq.sv
// lut_mult_seq: feeds an IN_W-bit operand one byte per cycle (LSB first)
// through a single lut_byte_mult slice and accumulates the shifted partial
// products into an exact P_W-bit product.
// Optional build macro LUT_MULT_SEQ_ZERO_SKIP_EN: finish early once every
// remaining higher byte of the operand is zero (results are unchanged).
module lut_mult_seq
   import lut_mult_pkg::*;
#(
   parameter int unsigned A_CONST = 2,
   parameter int          A_W     = 8,
   parameter int          IN_W    = 16,
   localparam int         P_W     = IN_W + A_W,
   localparam int         NCHUNK  = IN_W / CHUNK_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [P_W-1:0]  out_data,
   output logic            busy
);

   localparam int IDX_W = idx_width(NCHUNK);
   localparam int PPW   = CHUNK_W + A_W;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

   state_t                            state_q, state_d;
   logic [IN_W-1:0]                   op_q, op_d;
   logic [IDX_W-1:0]                  idx_q, idx_d;
   logic [P_W-1:0]                    acc_q, acc_d;

   logic [NCHUNK-1:0][CHUNK_W-1:0]    op_chunks;
   logic [CHUNK_W-1:0]                chunk;
   logic [PPW-1:0]                    pp;
   logic [P_W-1:0]                    pp_sh;
   logic                              last_chunk;

   assign op_chunks = op_q;
   assign chunk     = op_chunks[idx_q];

   lut_byte_mult #(
      .A_CONST (A_CONST),
      .A_W     (A_W)
   ) u_byte (
      .x_i (chunk),
      .p_o (pp)
   );

   // Byte weight: shift by 8*idx (chunks are bytes, hence the three zero bits).
   assign pp_sh = P_W'(pp) << {idx_q, 3'b000};

`ifdef LUT_MULT_SEQ_ZERO_SKIP_EN
   logic [NCHUNK-1:0] nz;
   logic [NCHUNK-1:0] nz_above;
   for (genvar c = 0; c < NCHUNK; c++) begin : g_nz
      assign nz[c] = |op_chunks[c];
   end
   assign nz_above   = (nz >> idx_q) >> 1;
   assign last_chunk = (idx_q == IDX_LAST) || (nz_above == '0);
`else
   assign last_chunk = (idx_q == IDX_LAST);
`endif

   // Next-state: accept in IDLE, accumulate one byte per cycle in RUN,
   // hold the product in DONE until the consumer takes it.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = in_data;
               acc_d   = '0;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_q + pp_sh;
            if (last_chunk) state_d = DONE;
            else            idx_d   = idx_q + IDX_W'(1);
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset discards any operand in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
      end
   end

   // The accumulator is the product register; it is frozen throughout DONE.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = acc_q;

endmodule

// File: tb/tb_lut_mult_seq.sv
// tb_lut_mult_seq: scoreboard bench. Two instances (A_CONST=2 and 200) share
// the input stream; every product is checked against x*A computed here.
module tb_lut_mult_seq;

   localparam int IN_W = 16;
   localparam int A_W  = 8;
   localparam int P_W  = IN_W + A_W;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b1;
   logic [IN_W-1:0] in_data = '0;
   logic            in_ready_a, out_valid_a, busy_a;
   logic            in_ready_b, out_valid_b, busy_b;
   logic [P_W-1:0]  out_data_a, out_data_b;

   always #5 clk = ~clk;

   lut_mult_seq #(.A_CONST(2), .A_W(A_W), .IN_W(IN_W)) u_dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_data(out_data_a), .busy(busy_a));

   lut_mult_seq #(.A_CONST(200), .A_W(A_W), .IN_W(IN_W)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_data(out_data_b), .busy(busy_b));

   typedef struct {
      logic [IN_W-1:0] x;
      logic [P_W-1:0]  e_a;
      logic [P_W-1:0]  e_b;
   } exp_t;

   exp_t sb[$];
   int   n_tot = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [IN_W-1:0] x);
      exp_t e;
      e.x   = x;
      e.e_a = P_W'(x) * 24'd2;
      e.e_b = P_W'(x) * 24'd200;
      return e;
   endfunction

   function automatic int lat_of(input logic [IN_W-1:0] x);
`ifdef LUT_MULT_SEQ_ZERO_SKIP_EN
      return (x[15:8] != 8'h00) ? 2 : 1;
`else
      return (x === x) ? 2 : 2;
`endif
   endfunction

   // Scoreboard: pop and compare on every output handshake.
   exp_t mon_e;
   always @(negedge clk) begin
      if (!rst && out_valid_a && out_ready) begin
         if (sb.size() == 0) begin
            chk("spurious_out", 32'(out_valid_a), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("prod_a", 32'(out_data_a), 32'(mon_e.e_a));
            chk("prod_b", 32'(out_data_b), 32'(mon_e.e_b));
            chk("vld_b", 32'(out_valid_b), 32'd1);
         end
      end
   end

   // Offer one operand in IDLE, then measure clocks until out_valid.
   task automatic send(input logic [IN_W-1:0] x);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready_a && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         chk("in_ready_timeout", 32'(in_ready_a), 32'd1);
         return;
      end
      in_valid = 1'b1;
      in_data  = x;
      sb.push_back(mk(x));
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid_a && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", 32'(n), 32'(lat_of(x)));
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      exp_t hold_e;
      int   n;
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t hold_e;
      int   n;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_vld", 32'(out_valid_a), 32'd0);
      chk("rst_data", 32'(out_data_a), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_rdy", 32'(in_ready_a), 32'd1);
      chk("rst_rdy_b", 32'(in_ready_b), 32'd1);

      // Basic product, single-cycle out_valid
      send(16'h1234);
      step();
      chk("t1_vld_1cyc", 32'(out_valid_a), 32'd0);
      chk("t1_lit", 32'(out_data_a), 32'h002468);

      // All ones and a sweep of the low byte
      send(16'hFFFF);
      step();
      chk("t2_lit", 32'(out_data_b), 32'hC7FF38);
      for (int i = 0; i < 256; i++)
         send({8'($urandom_range(0, 255)), 8'(i)});
      step();

      // Backpressure: product held, input refused
      out_ready = 1'b0;
      send(16'h0BEE);
      hold_e = mk(16'h0BEE);
      repeat (5) begin
         @(negedge clk);
         chk("t3_vld", 32'(out_valid_a), 32'd1);
         chk("t3_data", 32'(out_data_a), 32'(hold_e.e_a));
         chk("t3_rdy", 32'(in_ready_a), 32'd0);
      end
      step();
      out_ready = 1'b1;
      step();
      chk("t3_idle_busy", 32'(busy_a), 32'd0);
      chk("t3_idle_rdy", 32'(in_ready_a), 32'd1);
      chk("t3_idle_vld", 32'(out_valid_a), 32'd0);

      // in_valid held through RUN/DONE with changing data
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h4321;
      sb.push_back(mk(16'h4321));
      step();
      n = 0;
      while (!out_valid_a && n < 50) begin
         chk("t4_rdy_run", 32'(in_ready_a), 32'd0);
         in_data = 16'($urandom);
         step();
         n++;
      end
      in_data = 16'h0777;
      sb.push_back(mk(16'h0777));
      step();
      chk("t4_idle_rdy", 32'(in_ready_a), 32'd1);
      step();
      in_valid = 1'b0;
      chk("t4_accept_busy", 32'(busy_a), 32'd1);
      n = 0;
      while (!out_valid_a && n < 50) begin
         step();
         n++;
      end
      chk("t4_done", 32'(out_valid_a), 32'd1);
      step();

      // Reset mid-RUN discards the operand
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'hABCD;
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("t5_busy", 32'(busy_a), 32'd0);
      chk("t5_data", 32'(out_data_a), 32'd0);
      step();
      rst = 1'b0;
      repeat (4) begin
         chk("t5_no_vld", 32'(out_valid_a), 32'd0);
         step();
      end
      send(16'h0003);
      step();
      chk("t5_lit", 32'(out_data_a), 32'h000006);

      // Zero-chunk latency cases
      send(16'h0012);
      send(16'h0000);
      send(16'h0100);
      send(16'hFF00);
      step();
      step();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
